// File: rtl/stage2_window_buffer.sv
// Raster-order 5x5 sliding-window generator feeding the stage-2 conv kernel.
// One-cycle latency from completing pixel to window; no backpressure (one window per cycle max).
module stage2_window_buffer #(
   parameter int IMG_W = 12,
   parameter int IMG_H = 12,
   parameter int K     = 5,
   parameter int DW    = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_in_valid,
   input  logic                 i_frame_start,
   input  logic [DW-1:0]        i_in_pixel,
   output logic                 o_ot_valid,
   output logic [K*K*DW-1:0]    o_ot_fmap,
   output logic [3:0]           o_ot_row,
   output logic [3:0]           o_ot_col,
   output logic                 o_frame_done
);

   localparam logic [3:0] COL_LAST = 4'(IMG_W - 1);
   localparam logic [3:0] ROW_LAST = 4'(IMG_H - 1);
   localparam logic [3:0] KM1      = 4'(K - 1);

   logic [3:0]           col_q, col_d, row_q, row_d;
   logic [3:0]           cur_col, cur_row;
   logic [DW-1:0]        lb_q  [K-1][IMG_W];
   logic [DW-1:0]        lb_d  [K-1][IMG_W];
   logic [DW-1:0]        win_q [K][K];
   logic [DW-1:0]        win_d [K][K];
   logic                 ot_valid_q, ot_valid_d;
   logic                 frame_done_q, frame_done_d;
   logic [K*K*DW-1:0]    ot_fmap_q, ot_fmap_d;
   logic [3:0]           ot_row_q, ot_row_d, ot_col_q, ot_col_d;

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      lb_d         = lb_q;
      win_d        = win_q;
      ot_valid_d   = 1'b0;
      frame_done_d = 1'b0;
      ot_fmap_d    = ot_fmap_q;
      ot_row_d     = ot_row_q;
      ot_col_d     = ot_col_q;
      // A frame-start pixel is (0,0) whatever the counters say.
      cur_col      = i_frame_start ? 4'd0 : col_q;
      cur_row      = i_frame_start ? 4'd0 : row_q;

      if (i_in_valid) begin
         for (int y = 0; y < K; y++) begin
            for (int x = 0; x < K - 1; x++) begin
               win_d[y][x] = win_q[y][x+1];
            end
         end
         for (int y = 0; y < K - 1; y++) begin
            win_d[y][K-1] = lb_q[y][cur_col];
         end
         win_d[K-1][K-1] = i_in_pixel;

         for (int k = 0; k < K - 2; k++) begin
            lb_d[k][cur_col] = lb_q[k+1][cur_col];
         end
         lb_d[K-2][cur_col] = i_in_pixel;

         if (cur_col == COL_LAST) begin
            col_d = 4'd0;
            row_d = (cur_row == ROW_LAST) ? 4'd0 : cur_row + 4'd1;
         end else begin
            col_d = cur_col + 4'd1;
            row_d = cur_row;
         end

         // Window is complete only once K rows and K columns of this frame exist.
         if (cur_row >= KM1 && cur_col >= KM1) begin
            ot_valid_d   = 1'b1;
            ot_row_d     = cur_row - KM1;
            ot_col_d     = cur_col - KM1;
            frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            for (int y = 0; y < K; y++) begin
               for (int x = 0; x < K; x++) begin
                  ot_fmap_d[(y*K+x)*DW +: DW] = win_d[y][x];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q        <= 4'd0;
         row_q        <= 4'd0;
         win_q        <= '{default: '0};
         ot_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
         ot_fmap_q    <= '0;
         ot_row_q     <= 4'd0;
         ot_col_q     <= 4'd0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         ot_valid_q   <= ot_valid_d;
         frame_done_q <= frame_done_d;
         ot_fmap_q    <= ot_fmap_d;
         ot_row_q     <= ot_row_d;
         ot_col_q     <= ot_col_d;
      end
   end

   // Line buffers carry no reset; the emit condition keeps stale rows out of windows.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lb_q <= lb_d;
      end
   end

   assign o_ot_valid   = ot_valid_q;
   assign o_ot_fmap    = ot_fmap_q;
   assign o_ot_row     = ot_row_q;
   assign o_ot_col     = ot_col_q;
   assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_stage2_window_buffer.sv
// Bench for stage2_window_buffer: frame-image reference model compared every cycle,
// plus literal checks on selected windows.
module tb_stage2_window_buffer;

   localparam int W  = 12;
   localparam int H  = 12;
   localparam int K  = 5;
   localparam int DW = 20;
   localparam int FW = K*K*DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          frame_start;
   logic [DW-1:0] in_pixel;
   logic          ot_valid;
   logic [FW-1:0] ot_fmap;
   logic [3:0]    ot_row;
   logic [3:0]    ot_col;
   logic          frame_done;

   always #5 clk = ~clk;

   stage2_window_buffer #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_in_valid   (in_valid),
      .i_frame_start(frame_start),
      .i_in_pixel   (in_pixel),
      .o_ot_valid   (ot_valid),
      .o_ot_fmap    (ot_fmap),
      .o_ot_row     (ot_row),
      .o_ot_col     (ot_col),
      .o_frame_done (frame_done)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] elem(input logic [FW-1:0] f, input int y, input int x);
      return f[(y*K+x)*DW +: DW];
   endfunction

   // Reference model: keeps the current frame as an image and cuts windows out of it.
   logic [DW-1:0] img [H][W];
   int            mr = 0, mc = 0;
   logic          model_ready = 1'b0;
   logic          exp_valid, exp_done;
   logic [FW-1:0] exp_fmap;
   logic [3:0]    exp_row, exp_col;

   always @(posedge clk) begin
      if (reset) begin
         mr = 0; mc = 0;
         exp_valid = 1'b0; exp_done = 1'b0; exp_fmap = '0;
         exp_row = 4'd0; exp_col = 4'd0;
         model_ready = 1'b1;
      end else begin
         exp_valid = 1'b0;
         exp_done  = 1'b0;
         if (in_valid) begin
            if (frame_start) begin mr = 0; mc = 0; end
            img[mr][mc] = in_pixel;
            if (mr >= K-1 && mc >= K-1) begin
               exp_valid = 1'b1;
               exp_row   = 4'(mr - (K-1));
               exp_col   = 4'(mc - (K-1));
               exp_done  = (mr == H-1) && (mc == W-1);
               for (int y = 0; y < K; y++)
                  for (int x = 0; x < K; x++)
                     exp_fmap[(y*K+x)*DW +: DW] = img[mr-(K-1)+y][mc-(K-1)+x];
            end
            mc++;
            if (mc == W) begin
               mc = 0; mr++;
               if (mr == H) mr = 0;
            end
         end
      end
   end

   // Every emitted window is also logged for literal and cross-run checks.
   logic [FW-1:0] hist_fmap [1024];
   logic [3:0]    hist_row  [1024];
   logic [3:0]    hist_col  [1024];
   logic          hist_done [1024];
   int            win_total = 0;

   always @(negedge clk) begin
      if (model_ready) begin
         check("valid", FW'(ot_valid),   FW'(exp_valid));
         check("done",  FW'(frame_done), FW'(exp_done));
         check("row",   FW'(ot_row),     FW'(exp_row));
         check("col",   FW'(ot_col),     FW'(exp_col));
         check("fmap",  ot_fmap,         exp_fmap);
         if (ot_valid && win_total < 1024) begin
            hist_fmap[win_total] = ot_fmap;
            hist_row[win_total]  = ot_row;
            hist_col[win_total]  = ot_col;
            hist_done[win_total] = frame_done;
            win_total++;
         end
      end
   end

   task automatic cyc(input logic v, input logic fs, input logic [DW-1:0] p, input logic rst);
      @(posedge clk);
      #1;
      in_valid = v; frame_start = fs; in_pixel = p; reset = rst;
   endtask

   // mode 0: base+row*16+col, mode 1: alternating -1 / 0x80000, mode 2: random data
   task automatic send_frame(input int mode, input int base, input int gap, input int npix, input bit use_fs);
      logic [DW-1:0] p;
      for (int i = 0; i < npix; i++) begin
         while (gap > 0 && $urandom_range(99) < gap) cyc(1'b0, 1'b1, DW'($urandom), 1'b0);
         case (mode)
            0:       p = DW'(base + (i / W) * 16 + (i % W));
            1:       p = (i % 2 == 1) ? 20'h80000 : 20'hFFFFF;
            default: p = DW'($urandom);
         endcase
         cyc(1'b1, use_fs && (i == 0), p, 1'b0);
      end
   endtask

   task automatic flush();
      repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
   endtask

   int s, s_basic, ok;

   initial begin
      reset = 1'b1; in_valid = 1'b0; frame_start = 1'b0; in_pixel = '0;
      cyc(1'b0, 1'b0, '0, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      check("reset_valid", FW'(ot_valid), '0);
      check("reset_fmap",  ot_fmap,       '0);
      check("reset_rowcol", FW'({ot_row, ot_col, frame_done}), '0);

      // basic frame
      s_basic = win_total;
      send_frame(0, 0, 0, W*H, 1'b1);
      flush();
      check("basic_count", FW'(win_total - s_basic), FW'(64));
      check("basic_first_e00", FW'(elem(hist_fmap[s_basic], 0, 0)), FW'(20'h00));
      check("basic_first_e44", FW'(elem(hist_fmap[s_basic], 4, 4)), FW'(20'h44));
      check("basic_first_e23", FW'(elem(hist_fmap[s_basic], 2, 3)), FW'(20'h23));
      check("basic_first_rc",  FW'({hist_row[s_basic], hist_col[s_basic], hist_done[s_basic]}), FW'(9'd0));
      check("basic_last_rc",   FW'({hist_row[s_basic+63], hist_col[s_basic+63], hist_done[s_basic+63]}),
            FW'({4'd7, 4'd7, 1'b1}));

      // random valid gaps, same data
      s = win_total;
      send_frame(0, 0, 30, W*H, 1'b1);
      flush();
      check("gaps_count", FW'(win_total - s), FW'(64));
      ok = 1;
      for (int i = 0; i < 64; i++)
         if (hist_fmap[s+i] !== hist_fmap[s_basic+i] || hist_row[s+i] !== hist_row[s_basic+i] ||
             hist_col[s+i] !== hist_col[s_basic+i]) ok = 0;
      check("gaps_match_basic", FW'(ok), FW'(1));

      // signed passthrough
      s = win_total;
      send_frame(1, 0, 0, W*H, 1'b1);
      flush();
      check("signed_count", FW'(win_total - s), FW'(64));
      check("signed_e00", FW'(elem(hist_fmap[s], 0, 0)), FW'(20'hFFFFF));
      check("signed_e01", FW'(elem(hist_fmap[s], 0, 1)), FW'(20'h80000));

      // back-to-back frames, second without frame_start
      s = win_total;
      send_frame(0, 0, 0, W*H, 1'b1);
      send_frame(0, 256, 0, W*H, 1'b0);
      flush();
      check("b2b_count", FW'(win_total - s), FW'(128));
      check("b2b_second_e00", FW'(elem(hist_fmap[s+64], 0, 0)), FW'(20'h100));
      check("b2b_second_e44", FW'(elem(hist_fmap[s+64], 4, 4)), FW'(20'h144));

      // mid-frame reset, asserted together with a valid pixel
      send_frame(0, 0, 0, 30, 1'b1);
      cyc(1'b1, 1'b0, 20'hABCDE, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      check("midreset_valid", FW'(ot_valid), '0);
      check("midreset_fmap",  ot_fmap,       '0);
      check("midreset_rowcol", FW'({ot_row, ot_col}), '0);
      s = win_total;
      send_frame(0, 0, 0, W*H, 1'b0);
      flush();
      check("midreset_count", FW'(win_total - s), FW'(64));
      ok = 1;
      for (int i = 0; i < 64; i++)
         if (hist_fmap[s+i] !== hist_fmap[s_basic+i]) ok = 0;
      check("midreset_match_basic", FW'(ok), FW'(1));

      // resync by frame_start after 70 pixels, no gap
      s = win_total;
      send_frame(0, 0, 0, 70, 1'b1);
      send_frame(0, 0, 0, W*H, 1'b1);
      flush();
      check("resync_count", FW'(win_total - s), FW'(14 + 64));
      ok = 1;
      for (int i = 0; i < 64; i++)
         if (hist_fmap[s+14+i] !== hist_fmap[s_basic+i] || hist_row[s+14+i] !== hist_row[s_basic+i] ||
             hist_col[s+14+i] !== hist_col[s_basic+i]) ok = 0;
      check("resync_match_basic", FW'(ok), FW'(1));

      // random data with gaps
      s = win_total;
      send_frame(2, 0, 20, W*H, 1'b1);
      flush();
      check("random_count", FW'(win_total - s), FW'(64));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
